data_setup_a: RTL and testbench

- Sits between the matrix-A source ROM and the left edge of the systolic array.
- Snapshots one full ARRAY_W x ARRAY_L matrix on start.
- Replays it row-per-lane with diagonal skew, so array row i receives element k at step i+k.
- Produces per-lane valid flags, a busy level and a one-cycle done pulse.

---
 rtl/data_setup_a.sv | 129 ++++++++++++
 tb/tb_data_setup_a.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_setup_a.sv
// Skews a snapshotted ARRAY_W x ARRAY_L matrix onto the systolic array's left edge.
// Optional feature: define DATA_SETUP_A_STALL_EN to add a stall input that freezes streaming.
module data_setup_a #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W    = 5,
    parameter int ARRAY_L    = 2
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic                                              start,
`ifdef DATA_SETUP_A_STALL_EN
    input  logic                                              stall,
`endif
    input  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]   data_in,
    output logic [0:ARRAY_W-1][DATA_WIDTH-1:0]                data_out,
    output logic [0:ARRAY_W-1]                                valid_out,
    output logic                                              busy,
    output logic                                              done
);

    localparam int LAST   = ARRAY_W + ARRAY_L - 2;
    localparam int STEP_W = (LAST > 0) ? $clog2(LAST + 1) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(LAST);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e                                             state_q, state_d;
    logic [STEP_W-1:0]                                  step_q, step_d;
    logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]    buf_q, buf_d;
    logic [0:ARRAY_W-1][DATA_WIDTH-1:0]                 data_q, data_d;
    logic [0:ARRAY_W-1]                                 valid_q, valid_d;
    logic                                               done_q, done_d;

    logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]    srcMat;
    logic                                               loadStep;
    logic                                               stallActive;

`ifdef DATA_SETUP_A_STALL_EN
    assign stallActive = stall;
`else
    assign stallActive = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Step 0 is sourced straight from data_in so the first element leaves on the start edge.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        buf_d    = buf_q;
        data_d   = data_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        srcMat   = buf_q;
        loadStep = 1'b0;

        case (state_q)
            IDLE: begin
                data_d  = '0;
                valid_d = '0;
                if (start) begin
                    buf_d    = data_in;
                    srcMat   = data_in;
                    step_d   = '0;
                    state_d  = RUN;
                    loadStep = 1'b1;
                end
            end
            RUN: begin
                if (!stallActive) begin
                    if (step_q == LAST_STEP) begin
                        state_d = IDLE;
                        step_d  = '0;
                        data_d  = '0;
                        valid_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        step_d   = step_q + STEP_W'(1);
                        loadStep = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                data_d  = '0;
                valid_d = '0;
            end
        endcase

        if (loadStep) begin
            data_d  = '0;
            valid_d = '0;
            // Lane i carries element k exactly when i + k equals the step index.
            for (int i = 0; i < ARRAY_W; i++) begin
                for (int k = 0; k < ARRAY_L; k++) begin
                    if (STEP_W'(i + k) == step_d) begin
                        data_d[i]  = srcMat[i][k];
                        valid_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;

endmodule

// File: tb/tb_data_setup_a.sv
// Directed bench for data_setup_a: default 5x2 geometry plus 1x1 and 3x4 instances.
// Stall checks are compiled in only when DATA_SETUP_A_STALL_EN is defined.
module tb_data_setup_a;

    logic clk = 1'b0;
    logic reset_n;

    logic                 start;
    logic [0:4][0:1][7:0] dataIn;
    logic [0:4][7:0]      dataOut;
    logic [0:4]           validOut;
    logic                 busy;
    logic                 done;

    logic                 startOne;
    logic [0:0][0:0][7:0] dataInOne;
    logic [0:0][7:0]      dataOutOne;
    logic [0:0]           validOutOne;
    logic                 busyOne;
    logic                 doneOne;

    logic                 startWide;
    logic [0:2][0:3][7:0] dataInWide;
    logic [0:2][7:0]      dataOutWide;
    logic [0:2]           validOutWide;
    logic                 busyWide;
    logic                 doneWide;

`ifdef DATA_SETUP_A_STALL_EN
    logic                 stall;
`endif

    int total = 0;
    int bad   = 0;

    logic [4:0]  expValid [6];
    logic [39:0] expData  [6];
    logic [2:0]  expValidWide [6];

    always #5 clk = ~clk;

    data_setup_a #(.DATA_WIDTH(8), .ARRAY_W(5), .ARRAY_L(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
`ifdef DATA_SETUP_A_STALL_EN
        .stall     (stall),
`endif
        .data_in   (dataIn),
        .data_out  (dataOut),
        .valid_out (validOut),
        .busy      (busy),
        .done      (done)
    );

    data_setup_a #(.DATA_WIDTH(8), .ARRAY_W(1), .ARRAY_L(1)) dutOne (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (startOne),
`ifdef DATA_SETUP_A_STALL_EN
        .stall     (stall),
`endif
        .data_in   (dataInOne),
        .data_out  (dataOutOne),
        .valid_out (validOutOne),
        .busy      (busyOne),
        .done      (doneOne)
    );

    data_setup_a #(.DATA_WIDTH(8), .ARRAY_W(3), .ARRAY_L(4)) dutWide (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (startWide),
`ifdef DATA_SETUP_A_STALL_EN
        .stall     (stall),
`endif
        .data_in   (dataInWide),
        .data_out  (dataOutWide),
        .valid_out (validOutWide),
        .busy      (busyWide),
        .done      (doneWide)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, actual, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // fillFF selects the all-0xFF matrix instead of the 10*i+k+1 pattern.
    task automatic applyStimulus(input logic startVal, input bit fillFF);
        start = startVal;
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < 2; k++)
                dataIn[i][k] = fillFF ? 8'hFF : 8'(10 * i + k + 1);
    endtask

    task automatic checkStep(input string name, input int c, input bit ffFrame);
        logic [39:0] want;
        want = '0;
        if (ffFrame) begin
            for (int i = 0; i < 5; i++)
                if (expValid[c][4-i]) want[39-8*i -: 8] = 8'hFF;
        end else begin
            want = expData[c];
        end
        checkOutput($sformatf("%s step%0d valid", name, c), 64'(validOut), 64'(expValid[c]));
        checkOutput($sformatf("%s step%0d data", name, c), 64'(dataOut), 64'(want));
        checkOutput($sformatf("%s step%0d busy", name, c), 64'(busy), 64'd1);
        checkOutput($sformatf("%s step%0d done", name, c), 64'(done), 64'd0);
    endtask

    task automatic checkDoneCycle(input string name);
        checkOutput({name, " done pulse"}, 64'(done), 64'd1);
        checkOutput({name, " done busy"}, 64'(busy), 64'd0);
        checkOutput({name, " done valid"}, 64'(validOut), 64'd0);
        checkOutput({name, " done data"}, 64'(dataOut), 64'd0);
    endtask

    // Caller raises start before calling; the first edge here is the start edge.
    task automatic runFrame(input string name, input bit ffFrame);
        stepClock();
        start = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) stepClock();
            checkStep(name, c, ffFrame);
        end
        stepClock();
        checkDoneCycle(name);
        stepClock();
        checkOutput({name, " done clears"}, 64'(done), 64'd0);
    endtask

    initial begin
        expValid[0] = 5'b10000; expData[0] = 40'h01_00_00_00_00;
        expValid[1] = 5'b11000; expData[1] = 40'h02_0B_00_00_00;
        expValid[2] = 5'b01100; expData[2] = 40'h00_0C_15_00_00;
        expValid[3] = 5'b00110; expData[3] = 40'h00_00_16_1F_00;
        expValid[4] = 5'b00011; expData[4] = 40'h00_00_00_20_29;
        expValid[5] = 5'b00001; expData[5] = 40'h00_00_00_00_2A;
        expValidWide[0] = 3'b100; expValidWide[1] = 3'b110;
        expValidWide[2] = 3'b111; expValidWide[3] = 3'b111;
        expValidWide[4] = 3'b011; expValidWide[5] = 3'b001;

        reset_n   = 1'b0;
        startOne  = 1'b0;
        startWide = 1'b0;
        dataInOne[0][0] = 8'h5A;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++)
                dataInWide[i][k] = 8'(16 * i + k + 1);
`ifdef DATA_SETUP_A_STALL_EN
        stall = 1'b0;
`endif
        applyStimulus(1'b0, 1'b0);

        #3;
        checkOutput("reset valid", 64'(validOut), 64'd0);
        checkOutput("reset data", 64'(dataOut), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        stepClock();

        // Basic frame.
        applyStimulus(1'b1, 1'b0);
        runFrame("basic", 1'b0);

        // Restart and data change during RUN are ignored; start in the done cycle is accepted.
        applyStimulus(1'b1, 1'b0);
        stepClock();
        start = 1'b0;
        checkStep("frozen", 0, 1'b0);
        stepClock();
        checkStep("frozen", 1, 1'b0);
        stepClock();
        checkStep("frozen", 2, 1'b0);
        applyStimulus(1'b1, 1'b1);
        for (int c = 3; c <= 5; c++) begin
            stepClock();
            checkStep("frozen", c, 1'b0);
        end
        stepClock();
        checkDoneCycle("frozen");
        runFrame("backtoback", 1'b1);

        // Asynchronous reset mid-frame.
        applyStimulus(1'b1, 1'b0);
        stepClock();
        start = 1'b0;
        repeat (3) stepClock();
        checkStep("prereset", 3, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("abort valid", 64'(validOut), 64'd0);
        checkOutput("abort data", 64'(dataOut), 64'd0);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        repeat (2) begin
            stepClock();
            checkOutput("abort no done", 64'(done), 64'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        stepClock();
        applyStimulus(1'b1, 1'b0);
        runFrame("afterreset", 1'b0);

        // 1x1 geometry.
        startOne = 1'b1;
        stepClock();
        startOne = 1'b0;
        checkOutput("one valid", 64'(validOutOne), 64'd1);
        checkOutput("one data", 64'(dataOutOne), 64'h5A);
        checkOutput("one busy", 64'(busyOne), 64'd1);
        stepClock();
        checkOutput("one done", 64'(doneOne), 64'd1);
        checkOutput("one done valid", 64'(validOutOne), 64'd0);
        checkOutput("one done data", 64'(dataOutOne), 64'd0);

        // 3x4 geometry: six steps, lane 2 carries 0x21..0x24 during steps 2..5.
        startWide = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            stepClock();
            startWide = 1'b0;
            checkOutput($sformatf("wide step%0d valid", c), 64'(validOutWide), 64'(expValidWide[c]));
            checkOutput($sformatf("wide step%0d lane2", c), 64'(dataOutWide[2]),
                        (c >= 2) ? 64'(8'h21 + 8'(c - 2)) : 64'd0);
            checkOutput($sformatf("wide step%0d done", c), 64'(doneWide), 64'd0);
        end
        stepClock();
        checkOutput("wide done", 64'(doneWide), 64'd1);
        checkOutput("wide done valid", 64'(validOutWide), 64'd0);

`ifdef DATA_SETUP_A_STALL_EN
        // Three stalled cycles at step 2 hold outputs for four cycles and delay done by three.
        stepClock();
        applyStimulus(1'b1, 1'b0);
        stepClock();
        start = 1'b0;
        checkStep("stall", 0, 1'b0);
        stepClock();
        checkStep("stall", 1, 1'b0);
        stepClock();
        checkStep("stall", 2, 1'b0);
        stall = 1'b1;
        repeat (3) begin
            stepClock();
            checkStep("stall hold", 2, 1'b0);
        end
        stall = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            stepClock();
            checkStep("stall", c, 1'b0);
        end
        stepClock();
        checkDoneCycle("stall");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
